// File: rtl/switch_debouncer_pkg.sv
// rtl/switch_debouncer_pkg.sv - shared debounce defaults and counter sizing helper
package switch_debouncer_pkg;

   // Production stability window in clock cycles
   localparam int unsigned DB_STABLE_CYCLES_DEFAULT = 16;
   // Short window used to keep simulations fast
   localparam int unsigned DB_STABLE_CYCLES_SIM     = 4;
   // Level every synchronizer flop and debounced output takes in reset
   localparam logic        DB_INIT_VAL              = 1'b0;

   // Counter only has to reach STABLE_CYCLES-1; never narrower than one bit
   function automatic int unsigned db_cnt_width(input int unsigned stable_cycles);
      return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - WIDTH-wide two-flop synchronizer with async active-low reset
module sync_2ff #(
   parameter int unsigned WIDTH     = 1,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;

   // Two back-to-back flops give the first stage a full cycle to resolve metastability
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= {WIDTH{RESET_VAL}};
         sync2_q <= {WIDTH{RESET_VAL}};
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
      end
   end

   assign q_o = sync2_q;

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - multi-channel switch debouncer; DEBOUNCE_EDGE_PULSE_EN builds edge pulses
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned WIDTH         = 2,
   parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES_DEFAULT,
   parameter logic        INIT_VAL      = DB_INIT_VAL
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] db_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   localparam int unsigned    CW       = db_cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync_w;
   logic [WIDTH-1:0] db_w;
`ifdef DEBOUNCE_EDGE_PULSE_EN
   logic [WIDTH-1:0] db_nxt_w;
`endif

   sync_2ff #(
      .WIDTH     (WIDTH),
      .RESET_VAL (INIT_VAL)
   ) u_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (raw_in),
      .q_o    (sync_w)
   );

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d;
      logic          db_q, db_d;

      // Accept a new level only after it has differed from db_q for STABLE_CYCLES edges
      always_comb begin
         cnt_d = cnt_q;
         db_d  = db_q;
         if (sync_w[gi] == db_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            db_d  = sync_w[gi];
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Per-channel count and accepted level
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
            db_q  <= INIT_VAL;
         end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
         end
      end

      assign db_w[gi] = db_q;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      assign db_nxt_w[gi] = db_d;
`endif
   end

   assign db_out = db_w;

`ifdef DEBOUNCE_EDGE_PULSE_EN
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;

   // Pulses register on the same edge as db_out so they line up with the new level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= db_nxt_w & ~db_w;
         fall_q <= ~db_nxt_w & db_w;
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
`else
   assign rise_pulse = {WIDTH{1'b0}};
   assign fall_pulse = {WIDTH{1'b0}};
`endif

endmodule
